trdb_packet_serializer: RTL and testbench
=========================================

# trdb_packet_serializer

Sits directly downstream of `trdb_packet_emitter` and consumes its `packet_valid_o`, `packet_payload_o` and `payload_length_o`. It buffers complete packets in a small FIFO and emits each one as a 1-byte length header followed by its payload bytes. The bytes are packed LSB-first into fixed-width beats on a valid/ready stream toward the trace sink. Packets that arrive while the FIFO is full are dropped, flagged and counted, because the emitter has no backpressure input.

## Interface
Parameters:
- `BEAT_W`, 32: output beat width in bits; a multiple of 8 and ≤ PAYLOAD_LEN+8.
- `DEPTH`, 4: FIFO depth in whole packets; a power of two, ≥ 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `packet_valid_i`  in  1  the emitter's packet is valid this cycle.
- `packet_payload_i`  in  PAYLOAD_LEN  payload; byte 0 is bits [7:0].
- `payload_length_i`  in  P_LEN  payload length in bytes.
- `beat_valid_o`  out  1  a beat is presented.
- `beat_data_o`  out  BEAT_W  beat data; the lowest byte is sent first.
- `beat_last_o`  out  1  this is the final beat of the packet.
- `beat_ready_i`  in  1  the sink accepts the beat.
- `overflow_o`  out  1  one-cycle pulse when a packet is dropped.
- `drop_cnt_o`  out  8  count of dropped packets; saturates at 255.
- `empty_o`  out  1  FIFO empty and no packet in flight.

## Operation
- **Push:** occurs when `packet_valid_i` is high and `payload_length_i` is nonzero.
  - Length 0 is ignored: nothing is stored, no overflow is flagged.
  - A length greater than PAYLOAD_LEN/8 is clamped to PAYLOAD_LEN/8.
- **Entry format:** each FIFO entry is {len[7:0], payload}. Serialized byte stream = len, payload byte 0, …, payload byte len-1.
- **Beat count:** NB = BEAT_W/8 bytes per beat. Beats per packet = ceil((len+1)/NB).
  - Beat j carries stream bytes j·NB … j·NB+NB-1.
  - Bytes past the end of the stream are zero.
- **Head handling:** beats are built combinationally from the FIFO head and a beat counter `beat_idx`.
- **FSM states:**
  - IDLE: `beat_valid_o`=0. Moves to SEND when the FIFO is non-empty.
  - SEND: `beat_valid_o`=1.
    - On handshake (valid & ready) of a non-last beat: `beat_idx`++.
    - On handshake of the last beat: pop the head and clear `beat_idx`. Stay in SEND if the FIFO is still non-empty after the pop; otherwise go to IDLE.
- **Full FIFO:**
  - A push into a full FIFO is accepted if the same cycle also pops (last-beat handshake).
  - Otherwise the packet is dropped: `overflow_o`=1 for that cycle and `drop_cnt_o`++ (saturating).
- **Simultaneous push and pop on an empty-after-pop FIFO:** the FSM stays in SEND and the new packet's first beat is presented next cycle.
- **Reset mid-packet:** the packet is abandoned with no `beat_last_o`. The FIFO is flushed and `drop_cnt_o` is cleared.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, FIFO empty, `empty_o`=1.
- **Latency:** a packet sampled at edge k into an empty FIFO gives `beat_valid_o`=1 from just after edge k (combinational from the head), with no extra cycle.
- **Stability:** `beat_data_o` and `beat_last_o` are stable while `beat_valid_o` && !`beat_ready_i`. `beat_valid_o` never drops without a handshake, except on reset.
- **Throughput:** one beat per cycle with `beat_ready_i` held high. There is no bubble between packets.
- **Flags:** `overflow_o` is registered-free (combinational from the push-while-full condition). `drop_cnt_o` updates at the following edge.

## Structure
- `trdb_pkg` additions:
  - `SER_HDR_LEN` = 8.
  - typedef `trdb_ser_entry_s` {len, payload}.
  - typedef `trdb_ser_state_e` {IDLE, SEND}.
- Sub-module `trdb_pkt_fifo`: parameterised width/depth, synchronous active-high reset, same-cycle push-when-full-with-pop support, and full/empty/head outputs.
- The top level holds the FSM, the beat counter, beat assembly (byte mux), and the overflow counter.

## Test plan
All scenarios use BEAT_W=32 and DEPTH=4.
- **Single-beat packet:** length 3, payload 0xCCBBAA → one beat 0xCCBBAA03 with `beat_last_o`=1 and `beat_valid_o` in the same cycle after the push; then `empty_o`=1.
- **Two-beat packet:** length 7, bytes 0x11..0x77 → beats 0x33221107, then 0x77665544 with last=1.
- **Backpressure:** `beat_ready_i`=0 for 5 cycles mid-packet → data held constant, no beat skipped or duplicated; completes after ready returns.
- **Overflow:** with `beat_ready_i`=0, push 5 packets → 5th dropped, `overflow_o` pulses once, `drop_cnt_o`=1. Draining then yields exactly packets 1–4 in order.
- **Full FIFO, push with pop:** push into a full FIFO in the same cycle as a last-beat handshake → packet accepted, no overflow. A length-0 push → no state change.
- **Reset mid-packet:** assert `rst_i` during beat 0 of a 2-beat packet → next cycle all outputs 0, `empty_o`=1, `drop_cnt_o`=0.

Source files
------------

// File: rtl/trdb_packet_serializer_pkg.sv
// ============================================================================
// trdb_packet_serializer_pkg : shared types and constants for the serializer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package trdb_packet_serializer_pkg;

  localparam int PAYLOAD_LEN       = 64;
  localparam int P_LEN             = 4;
  localparam int SER_HDR_LEN       = 8;
  localparam int MAX_PAYLOAD_BYTES = PAYLOAD_LEN / 8;

  typedef struct packed {
    logic [SER_HDR_LEN-1:0] len;
    logic [PAYLOAD_LEN-1:0] payload;
  } trdb_ser_entry_s;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } trdb_ser_state_e;

endpackage

`default_nettype wire

// File: rtl/trdb_packet_serializer_if.sv
// ============================================================================
// trdb_packet_serializer_if : valid/ready beat stream toward the trace sink
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface trdb_packet_serializer_if #(
  parameter int BEAT_W = 32
);

  logic              beat_valid_o;
  logic [BEAT_W-1:0] beat_data_o;
  logic              beat_last_o;
  logic              beat_ready_i;

  modport master (
    output beat_valid_o,
    output beat_data_o,
    output beat_last_o,
    input  beat_ready_i
  );

  modport slave (
    input  beat_valid_o,
    input  beat_data_o,
    input  beat_last_o,
    output beat_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/trdb_packet_serializer_fifo.sv
// ============================================================================
// trdb_pkt_fifo : whole-packet FIFO, accepts a push when full if it also pops
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module trdb_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           push_data,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           head,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign count     = r_wr_ptr - r_rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (c_AW+1)'(DEPTH));
  assign head      = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_do_pop  = pop && !empty;
  // The slot freed by a same-cycle pop may be reused immediately.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trdb_packet_serializer.sv
// ============================================================================
// trdb_packet_serializer : buffers packets, emits length header + payload beats
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module trdb_packet_serializer
  import trdb_packet_serializer_pkg::*;
#(
  parameter int BEAT_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  input  wire logic                   packet_valid_i,
  input  wire logic [PAYLOAD_LEN-1:0] packet_payload_i,
  input  wire logic [P_LEN-1:0]       payload_length_i,
  trdb_packet_serializer_if.master    beat_if,
  output logic                        overflow_o,
  output logic      [7:0]             drop_cnt_o,
  output logic                        empty_o
);

  localparam int c_NB     = BEAT_W / 8;
  localparam int c_AW     = $clog2(DEPTH);
  localparam int c_STREAM = MAX_PAYLOAD_BYTES + 1;

  trdb_ser_state_e  r_state;
  logic [7:0]       r_beat_idx;
  logic [7:0]       r_drop_cnt;

  logic [P_LEN-1:0] w_len_clamped;
  trdb_ser_entry_s  w_push_entry;
  trdb_ser_entry_s  w_head;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [c_AW:0]    w_fifo_count;
  logic             w_beat_valid;
  logic             w_handshake;
  logic             w_last;
  logic [7:0]       w_last_idx;
  logic [31:0]      w_base;
  logic [7:0]       w_stream [c_STREAM];
  logic [BEAT_W-1:0] w_beat_data;

  assign w_len_clamped = (payload_length_i > P_LEN'(MAX_PAYLOAD_BYTES)) ?
                         P_LEN'(MAX_PAYLOAD_BYTES) : payload_length_i;
  assign w_push_entry  = '{len: SER_HDR_LEN'(w_len_clamped), payload: packet_payload_i};

  assign w_beat_valid = (r_state == SEND);
  assign w_handshake  = w_beat_valid && beat_if.beat_ready_i;
  assign w_last_idx   = 8'((32'(w_head.len) + c_NB) / c_NB - 1);
  assign w_last       = (r_beat_idx == w_last_idx);
  assign w_pop        = w_handshake && w_last;

  // The emitter cannot be stalled, so a push into a full FIFO without a pop is lost.
  assign w_push_req   = packet_valid_i && (payload_length_i != '0) && !rst_i;
  assign w_push       = w_push_req && (!w_fifo_full || w_pop);
  assign overflow_o   = w_push_req && w_fifo_full && !w_pop;

  trdb_pkt_fifo #(
    .WIDTH ($bits(trdb_ser_entry_s)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  always_comb begin
    w_stream[0] = w_head.len;
    for (int i = 1; i < c_STREAM; i++) begin
      w_stream[i] = (8'(i) <= w_head.len) ? w_head.payload[8*(i-1) +: 8] : 8'h00;
    end
  end

  assign w_base = 32'(r_beat_idx) * c_NB;

  // Byte lane b of the beat carries stream byte beat_idx*NB + b, zero past the end.
  always_comb begin
    w_beat_data = '0;
    for (int b = 0; b < c_NB; b++) begin
      for (int s = 0; s < c_STREAM; s++) begin
        if (w_base + 32'(b) == 32'(s)) begin
          w_beat_data[8*b +: 8] = w_stream[s];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_beat_idx <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty || w_push) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_handshake) begin
            if (w_last) begin
              r_beat_idx <= '0;
              if ((w_fifo_count <= (c_AW+1)'(1)) && !w_push) begin
                r_state <= IDLE;
              end
            end else begin
              r_beat_idx <= r_beat_idx + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (overflow_o && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign beat_if.beat_valid_o = w_beat_valid;
  assign beat_if.beat_data_o  = w_beat_valid ? w_beat_data : '0;
  assign beat_if.beat_last_o  = w_beat_valid && w_last;
  assign drop_cnt_o           = r_drop_cnt;
  assign empty_o              = w_fifo_empty && (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_trdb_packet_serializer.sv
// ============================================================================
// tb_trdb_packet_serializer : directed + random stimulus against a packet model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_trdb_packet_serializer;
  import trdb_packet_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv  = 1'b0;
  logic [63:0] pay = '0;
  logic [3:0]  plen = '0;
  logic        ovf;
  logic [7:0]  dcnt;
  logic        empty;

  int n_cmp  = 0;
  int n_fail = 0;

  // Packet-level reference: queued packets, current beat of the head, drops.
  int          q_len[$];
  logic [63:0] q_pay[$];
  int          m_beat  = 0;
  int          m_drops = 0;

  trdb_packet_serializer_if #(.BEAT_W(32)) bif ();

  trdb_packet_serializer #(
    .BEAT_W (32),
    .DEPTH  (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .packet_valid_i   (pv),
    .packet_payload_i (pay),
    .payload_length_i (plen),
    .beat_if          (bif),
    .overflow_o       (ovf),
    .drop_cnt_o       (dcnt),
    .empty_o          (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_beat(input int len, input logic [63:0] p, input int j);
    logic [7:0]  s[$];
    logic [31:0] r;
    r = '0;
    s.push_back(8'(len));
    for (int i = 0; i < len; i++) s.push_back(p[8*i +: 8]);
    for (int b = 0; b < 4; b++) begin
      if (j*4 + b < s.size()) r[8*b +: 8] = s[j*4 + b];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the negedge, check outputs, then advance the model past the posedge.
  task automatic cycle(input logic v, input int len, input logic [63:0] p, input logic rdy);
    logic        ev, el, eo, pop, preq;
    logic [31:0] ed;
    int          nb;
    pv = v; plen = 4'(len); pay = p; bif.beat_ready_i = rdy;
    #1;
    ev = (q_len.size() > 0);
    ed = '0; el = 1'b0;
    if (ev) begin
      nb = (q_len[0] + 1 + 3) / 4;
      ed = exp_beat(q_len[0], q_pay[0], m_beat);
      el = (m_beat == nb - 1);
    end
    pop  = ev && rdy && el;
    preq = v && (len != 0);
    eo   = preq && (q_len.size() == 4) && !pop;
    chk("valid",    32'(bif.beat_valid_o), 32'(ev));
    chk("data",     bif.beat_data_o,       ed);
    chk("last",     32'(bif.beat_last_o),  32'(el));
    chk("overflow", 32'(ovf),              32'(eo));
    chk("drop_cnt", 32'(dcnt),             32'(m_drops));
    chk("empty",    32'(empty),            32'(q_len.size() == 0));
    @(posedge clk);
    if (ev && rdy) begin
      if (el) begin
        void'(q_len.pop_front());
        void'(q_pay.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (preq && !eo) begin
      q_len.push_back(len > 8 ? 8 : len);
      q_pay.push_back(p);
    end
    if (eo && m_drops < 255) m_drops++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = 1'b0; plen = '0; bif.beat_ready_i = 1'b0;
    @(posedge clk);
    q_len.delete(); q_pay.delete(); m_beat = 0; m_drops = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 64'h0, 1'b1);
  endtask

  initial begin
    bif.beat_ready_i = 1'b0;
    do_reset();
    cycle(1'b0, 0, 64'h0, 1'b0);

    // Single-beat packet
    cycle(1'b1, 3, 64'hCCBBAA, 1'b1);
    pv = 1'b0; plen = '0; bif.beat_ready_i = 1'b1;
    #1 chk("single_lit", bif.beat_data_o, 32'hCCBBAA03);
    drain(2);

    // Two-beat packet
    cycle(1'b1, 7, 64'h0077665544332211, 1'b1);
    pv = 1'b0; plen = '0; bif.beat_ready_i = 1'b1;
    #1 chk("two_beat0_lit", bif.beat_data_o, 32'h33221107);
    drain(3);

    // Backpressure mid-packet
    cycle(1'b1, 7, 64'h0807060504030201, 1'b1);
    cycle(1'b0, 0, 64'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 64'h0, 1'b0);
    drain(3);

    // Overflow: five pushes with the sink stalled
    for (int i = 1; i <= 5; i++) cycle(1'b1, i, {$urandom, $urandom}, 1'b0);
    cycle(1'b0, 0, 64'h0, 1'b0);
    drain(12);

    // Full FIFO push coinciding with a last-beat pop, then a length-0 push
    for (int i = 0; i < 4; i++) cycle(1'b1, 2, {$urandom, $urandom}, 1'b0);
    cycle(1'b1, 5, {$urandom, $urandom}, 1'b1);
    cycle(1'b1, 0, {$urandom, $urandom}, 1'b0);
    drain(10);

    // Length clamp
    cycle(1'b1, 15, {$urandom, $urandom}, 1'b1);
    cycle(1'b1, 9, {$urandom, $urandom}, 1'b1);
    drain(8);

    // Reset during beat 0 of a two-beat packet
    cycle(1'b1, 7, {$urandom, $urandom}, 1'b0);
    cycle(1'b0, 0, 64'h0, 1'b0);
    do_reset();
    cycle(1'b0, 0, 64'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            {$urandom, $urandom}, 1'($urandom_range(0, 9) < 7));
    end
    drain(20);

    // Drop counter saturation
    for (int i = 0; i < 265; i++) cycle(1'b1, 1, {$urandom, $urandom}, 1'b0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
